// File: rtl/huff_bitstream_packer_if.sv
// ---------------------------------------------------------------------------
// huff_bitstream_packer_if
// Streaming handshake bundle for huff_bitstream_packer.
//   sym_valid/sym_ready/sym_data/sym_last : symbol stream into the packer
//   out_valid/out_ready/out_data/out_nbits/out_last : packed words out
// The master modport is the side that feeds symbols in and takes words out.
// The slave modport is the packer itself.
// ---------------------------------------------------------------------------
interface huff_bitstream_packer_if #(
  parameter int SYM_W = 8,
  parameter int OUT_W = 32
);
  localparam int NB_W = $clog2(OUT_W + 1);

  logic             sym_valid;
  logic             sym_ready;
  logic [SYM_W-1:0] sym_data;
  logic             sym_last;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [NB_W-1:0]  out_nbits;
  logic             out_last;

  modport master (
    output sym_valid, sym_data, sym_last, out_ready,
    input  sym_ready, out_valid, out_data, out_nbits, out_last
  );

  modport slave (
    input  sym_valid, sym_data, sym_last, out_ready,
    output sym_ready, out_valid, out_data, out_nbits, out_last
  );
endinterface

// File: rtl/huff_bitstream_packer.sv
// ---------------------------------------------------------------------------
// huff_bitstream_packer
// Looks up each incoming symbol in a run-time loadable Huffman code table and
// concatenates the variable-length codes MSB-first into OUT_W-bit words.
//   clk          : rising-edge clock
//   reset        : asynchronous, active-low reset
//   tbl_we_i     : table write strobe (honoured only while idle)
//   tbl_addr_i   : symbol whose entry is written
//   tbl_code_i   : code value, right-justified
//   tbl_len_i    : code length, 0 marks an unused symbol
//   bus          : symbol stream in / packed word stream out (slave side)
//   busy_o       : a stream is in progress
//   err_o        : sticky error (write while busy, or unused symbol seen)
//   sym_count_o  : symbols accepted in the current stream
//   bit_count_o  : code bits packed in the current stream
// Optional macro HUFF_PACK_STATS_EN builds the two statistics counters;
// without it they are tied to 0.
// ---------------------------------------------------------------------------
module huff_bitstream_packer #(
  parameter int SYM_W        = 8,
  parameter int MAX_CODE_LEN = 16,
  parameter int OUT_W        = 32,
  parameter int LEN_W        = $clog2(MAX_CODE_LEN + 1),
  parameter int CNT_W        = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tbl_we_i,
  input  logic [SYM_W-1:0]        tbl_addr_i,
  input  logic [MAX_CODE_LEN-1:0] tbl_code_i,
  input  logic [LEN_W-1:0]        tbl_len_i,
  huff_bitstream_packer_if.slave  bus,
  output logic                    busy_o,
  output logic                    err_o,
  output logic [CNT_W-1:0]        sym_count_o,
  output logic [CNT_W-1:0]        bit_count_o
);
  localparam int NUM_SYM = 2 ** SYM_W;
  localparam int ACC_W   = OUT_W + MAX_CODE_LEN;
  localparam int FILL_W  = $clog2(ACC_W + 1);
  localparam int NB_W    = $clog2(OUT_W + 1);
  localparam logic [FILL_W-1:0] OUT_W_F = FILL_W'(OUT_W);

  typedef enum logic [1:0] {IDLE, PACK, FLUSH} state_t;

  state_t                  state_q, state_d;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic [FILL_W-1:0]       fill_q, fill_d;
  logic                    err_q, err_d;
  logic [MAX_CODE_LEN-1:0] code_q [NUM_SYM];
  logic [LEN_W-1:0]        len_q  [NUM_SYM];

  logic                    sym_ready_w, out_valid_w, out_last_w;
  logic [NB_W-1:0]         out_nbits_w;
  logic                    accept, pop, tbl_ok;
  logic [MAX_CODE_LEN-1:0] sym_code, code_m;
  logic [LEN_W-1:0]        sym_len;
  logic [ACC_W-1:0]        code_top, acc_base;
  logic [FILL_W-1:0]       take, fill_base;

  assign accept   = bus.sym_valid && sym_ready_w;
  assign pop      = out_valid_w && bus.out_ready;
  assign tbl_ok   = tbl_we_i && (state_q == IDLE);
  assign sym_code = code_q[bus.sym_data];
  assign sym_len  = len_q[bus.sym_data];

  // Code table: lengths reset so every symbol starts out unused.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_SYM; i++) len_q[i] <= '0;
    end else if (tbl_ok) begin
      len_q[tbl_addr_i] <= tbl_len_i;
    end
  end

  always_ff @(posedge clk) begin
    if (tbl_ok) code_q[tbl_addr_i] <= tbl_code_i;
  end

  // State, accumulator and error registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      fill_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      fill_q  <= fill_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = bus.sym_last ? FLUSH : PACK;
      PACK:    if (accept && bus.sym_last) state_d = FLUSH;
      FLUSH:   if (pop && out_last_w) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sym_ready_w = 1'b0;
    out_valid_w = 1'b0;
    out_last_w  = 1'b0;
    out_nbits_w = '0;
    case (state_q)
      IDLE: sym_ready_w = reset;
      PACK: begin
        sym_ready_w = (fill_q < OUT_W_F);
        out_valid_w = (fill_q >= OUT_W_F);
        out_nbits_w = out_valid_w ? NB_W'(OUT_W) : '0;
      end
      FLUSH: begin
        out_valid_w = 1'b1;
        out_last_w  = (fill_q <= OUT_W_F);
        out_nbits_w = (fill_q > OUT_W_F) ? NB_W'(OUT_W) : NB_W'(fill_q);
      end
      default: ;
    endcase
  end

  // Datapath: pop first, then append the new code right below what is left.
  // Bits above len in the table entry are masked so they cannot leak in.
  always_comb begin
    take      = (fill_q > OUT_W_F) ? OUT_W_F : fill_q;
    acc_base  = pop ? (acc_q << OUT_W) : acc_q;
    fill_base = pop ? (fill_q - take) : fill_q;
    code_m    = sym_code & ~({MAX_CODE_LEN{1'b1}} << sym_len);
    code_top  = {code_m, {OUT_W{1'b0}}} << (LEN_W'(MAX_CODE_LEN) - sym_len);
    acc_d     = acc_base;
    fill_d    = fill_base;
    if (accept) begin
      acc_d  = acc_base | (code_top >> fill_base);
      fill_d = fill_base + FILL_W'(sym_len);
    end
    err_d = err_q | (tbl_we_i && !tbl_ok) | (accept && (sym_len == '0));
  end

  assign bus.sym_ready = sym_ready_w;
  assign bus.out_valid = out_valid_w;
  assign bus.out_last  = out_last_w;
  assign bus.out_nbits = out_nbits_w;
  // Bits below fill are always zero, so the top slice is already masked.
  assign bus.out_data  = acc_q[ACC_W-1 -: OUT_W];
  assign busy_o        = (state_q != IDLE);
  assign err_o         = err_q;

`ifdef HUFF_PACK_STATS_EN
  logic [CNT_W-1:0] sym_cnt_q, bit_cnt_q;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  // The first accept out of IDLE restarts both counts for the new stream.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sym_cnt_q <= '0;
      bit_cnt_q <= '0;
    end else if (accept) begin
      if (state_q == IDLE) begin
        sym_cnt_q <= CNT_W'(1);
        bit_cnt_q <= CNT_W'(sym_len);
      end else begin
        sym_cnt_q <= sat_add(sym_cnt_q, CNT_W'(1));
        bit_cnt_q <= sat_add(bit_cnt_q, CNT_W'(sym_len));
      end
    end
  end

  assign sym_count_o = sym_cnt_q;
  assign bit_count_o = bit_cnt_q;
`else
  assign sym_count_o = '0;
  assign bit_count_o = '0;
`endif
endmodule

// File: doc/huff_bitstream_packer.md
Name: huff_bitstream_packer

Overview:
Parametrised streaming successor to huff_encoder. Holds a run-time loadable Huffman code table (code value + length per symbol) and accepts a symbol stream over valid/ready. It concatenates the variable-length codes MSB-first into fixed-width output words, also over valid/ready. It sits between the code-generation stage (huff_encoder results written into the table) and the downstream bus/FIFO.

Parameters:
SYM_W, 8, symbol width; table depth NUM_SYM = 2**SYM_W
MAX_CODE_LEN, 16, maximum code length in bits; must be 1..OUT_W
OUT_W, 32, output word width in bits
LEN_W, $clog2(MAX_CODE_LEN+1), width of the length fields
CNT_W, 32, width of the statistics counters

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
tbl_we  in  1  table write strobe
tbl_addr  in  SYM_W  symbol whose entry is written
tbl_code  in  MAX_CODE_LEN  code value, right-justified
tbl_len  in  LEN_W  code length; 0 = symbol unused
sym_valid  in  1  symbol available
sym_ready  out  1  symbol accepted when sym_valid&&sym_ready
sym_data  in  SYM_W  symbol
sym_last  in  1  final symbol of the stream
out_valid  out  1  output word available
out_ready  in  1  downstream accepts the word
out_data  out  OUT_W  packed bits; first bit at out_data[OUT_W-1]
out_nbits  out  $clog2(OUT_W+1)  number of valid bits in out_data
out_last  out  1  final word of the stream
busy  out  1  state != IDLE
err  out  1  sticky error flag; cleared only by reset
sym_count  out  CNT_W  symbols accepted in the current stream (optional feature)
bit_count  out  CNT_W  code bits packed in the current stream (optional feature)

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, fill=0, accumulator=0, every table length=0, err=0, counters=0. All outputs read 0 except sym_ready, which reads 1 once reset is released.
- Accumulator ACC_W = OUT_W+MAX_CODE_LEN bits, MSB-aligned; fill = number of valid bits held.
- Table: register array, read combinationally by sym_data.
  - A write lands on the clock edge only in IDLE.
  - tbl_we outside IDLE is dropped and sets err.
- FSM states: IDLE, PACK, FLUSH.
  - IDLE: sym_ready=1, out_valid=0. Accepting a symbol moves to PACK, or to FLUSH if sym_last=1.
  - PACK: sym_ready = (fill < OUT_W). Accepting a symbol with sym_last=1 moves to FLUSH.
  - FLUSH: sym_ready=0. Every word is emitted; after the word with out_last=1 is accepted, the state returns to IDLE.
- Append: on accept, the code's tbl_len bits (bit len-1 first) are placed immediately below the current fill; fill += len.
  - Because fill < OUT_W at accept time, the accumulator never overflows.
- A symbol with len=0 is consumed, appends nothing and sets err.
- out_valid rules:
  - PACK: out_valid = (fill >= OUT_W), with out_nbits=OUT_W and out_last=0.
  - FLUSH: out_valid=1, out_nbits = min(fill, OUT_W), out_last = (fill <= OUT_W).
  - Unused low bits of out_data are 0.
  - If FLUSH is entered with fill=0, one word is emitted: out_data=0, out_nbits=0, out_last=1.
- Pop (out_valid&&out_ready): the accumulator shifts left by OUT_W; fill -= min(fill, OUT_W).
- Pop and accept in the same cycle: both apply, giving fill_next = fill - OUT_W + len.
- Latency: a code accepted on edge N appears in out_data from cycle N+1.
- Output stability: out_data, out_nbits and out_last hold steady while out_valid=1 and out_ready=0.

Optional Feature:
HUFF_PACK_STATS_EN:
- Defined: sym_count increments on every accepted symbol, including len=0 symbols. bit_count adds len on each accepted symbol. Both clear on the first accept out of IDLE and saturate at all-ones. Both hold their values after the stream ends, until the next stream starts.
- Undefined: sym_count and bit_count are tied to 0. No counter logic is built.

Test Plan:
1. Table: 'a'=0b0/len1, 'b'=0b10/len2, 'c'=0b11/len2; stream "abc", sym_last on 'c', out_ready=1 -> one word 0x58000000, out_nbits=5, out_last=1; busy then drops; err=0.
2. 16 × 'b' with sym_last on the 16th -> exactly one word 0xAAAAAAAA, out_nbits=32, out_last=1; no trailing empty word.
3. out_ready=0 while streaming 20 × 'b' -> sym_ready drops once fill reaches 32; out_data=0xAAAAAAAA stays stable. After out_ready=1 the stream resumes; on sym_last the final word is 0xAAAAAAAA with nbits=8 masked high, i.e. 0xAA000000, nbits=8.
4. Symbol 'z' with len=0, then 'a' with last -> err=1; output 0x00000000, nbits=1, last=1. With HUFF_PACK_STATS_EN: sym_count=2, bit_count=1.
5. tbl_we during PACK for 'a' -> err=1 and the entry is unchanged (next 'a' still emits a single 0 bit).
6. reset asserted mid-FLUSH, between clock edges -> out_valid, busy, err and the counters read 0 immediately. After release, a fresh 'a' is rejected as len=0 (table cleared) and sets err.
